// File: rtl/str_freq_monitor.sv
// Frequency monitor for a self-timed ring tap: synchronizes the tap, counts rising edges per gate window, flags stalls.
// Optional min/max window tracking is compiled in with `define STR_MONITOR_MINMAX_EN.
module str_freq_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int GATE_W      = 16,
   parameter int STALL_W     = 12
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               RING_TAP,
   input  logic               START,
   input  logic [GATE_W-1:0]  GATE_LEN,
   input  logic [STALL_W-1:0] STALL_LIMIT,
   output logic [CNT_W-1:0]   COUNT_OUT,
   output logic               COUNT_VALID,
   input  logic               COUNT_READY,
   output logic               OVERFLOW,
   output logic               STALL,
   output logic               BUSY
`ifdef STR_MONITOR_MINMAX_EN
   ,
   input  logic               MINMAX_CLR,
   output logic [CNT_W-1:0]   MIN_COUNT,
   output logic [CNT_W-1:0]   MAX_COUNT
`endif
);

   localparam int WARM   = SYNC_STAGES + 1;
   localparam int WARM_W = $clog2(WARM + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

   state_t              state_reg, state_next;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                prev_reg;
   logic                rise_reg;
   logic                edge_reg;
   logic [WARM_W-1:0]   warm_reg;
   logic                warm_done;
   logic                synced;
   logic [STALL_W-1:0]  timer_reg;
   logic [GATE_W-1:0]   gate_reg;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic                ovf_acc_reg, ovf_next;
   logic [CNT_W-1:0]    count_out_reg;
   logic                valid_reg;
   logic                overflow_reg;
   logic                load_ok;
   logic                load, finish, xfer;

   assign synced    = sync_reg[SYNC_STAGES-1];
   assign warm_done = (warm_reg == WARM_W'(WARM));

   // Synchronizer, edge detect and warm-up mask
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sync_reg <= '0;
         prev_reg <= 1'b0;
         rise_reg <= 1'b0;
         edge_reg <= 1'b0;
         warm_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], RING_TAP};
         prev_reg <= synced;
         rise_reg <= warm_done & synced & ~prev_reg;
         edge_reg <= warm_done & (synced ^ prev_reg);
         if (!warm_done)
            warm_reg <= warm_reg + WARM_W'(1);
      end
   end

   // Stall timer is clamped whenever the limit drops below it
   always_ff @(posedge CLK) begin
      if (!RST_N)
         timer_reg <= '0;
      else if (edge_reg)
         timer_reg <= '0;
      else if (timer_reg >= STALL_LIMIT)
         timer_reg <= STALL_LIMIT;
      else
         timer_reg <= timer_reg + STALL_W'(1);
   end

   assign STALL = (STALL_LIMIT != '0) && (timer_reg >= STALL_LIMIT);

   always_ff @(posedge CLK) begin
      if (!RST_N)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   assign load_ok = START && (GATE_LEN != '0);

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      finish     = 1'b0;
      xfer       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (load_ok) begin
               load       = 1'b1;
               state_next = MEASURE;
            end
         end
         MEASURE: begin
            if (gate_reg == GATE_W'(1)) begin
               finish     = 1'b1;
               state_next = REPORT;
            end
         end
         REPORT: begin
            if (valid_reg && COUNT_READY) begin
               xfer = 1'b1;
               if (load_ok) begin
                  load       = 1'b1;
                  state_next = MEASURE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Saturating count; a rise while saturated marks the window as overflowed
   always_comb begin
      count_next = count_reg;
      ovf_next   = ovf_acc_reg;
      if (rise_reg) begin
         if (count_reg == CNT_MAX)
            ovf_next = 1'b1;
         else
            count_next = count_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         gate_reg      <= '0;
         count_reg     <= '0;
         ovf_acc_reg   <= 1'b0;
         count_out_reg <= '0;
         valid_reg     <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         if (load) begin
            gate_reg     <= GATE_LEN;
            count_reg    <= '0;
            ovf_acc_reg  <= 1'b0;
            overflow_reg <= 1'b0;
         end else if (state_reg == MEASURE) begin
            gate_reg    <= gate_reg - GATE_W'(1);
            count_reg   <= count_next;
            ovf_acc_reg <= ovf_next;
         end
         if (finish) begin
            count_out_reg <= count_next;
            overflow_reg  <= ovf_next;
            valid_reg     <= 1'b1;
         end else if (xfer) begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign COUNT_OUT   = count_out_reg;
   assign COUNT_VALID = valid_reg;
   assign OVERFLOW    = overflow_reg;
   assign BUSY        = (state_reg != IDLE);

`ifdef STR_MONITOR_MINMAX_EN
   logic [CNT_W-1:0] min_reg, max_reg;

   always_ff @(posedge CLK) begin
      if (!RST_N || MINMAX_CLR) begin
         min_reg <= CNT_MAX;
         max_reg <= '0;
      end else if (finish) begin
         if (count_next < min_reg)
            min_reg <= count_next;
         if (count_next > max_reg)
            max_reg <= count_next;
      end
   end

   assign MIN_COUNT = min_reg;
   assign MAX_COUNT = max_reg;
`endif

endmodule

// File: tb/tb_str_freq_monitor.sv
// Directed bench for str_freq_monitor; a second instance with a 4-bit counter covers saturation.
// Min/max checks are active when STR_MONITOR_MINMAX_EN is defined.
module tb_str_freq_monitor;

   localparam int SYNC = 2;

   logic        clk;
   logic        rst_n;
   logic        tap;
   logic        start;
   logic [15:0] gate_len;
   logic [11:0] stall_limit;
   logic        count_ready;
   logic [15:0] count_out;
   logic        count_valid, overflow, stall, busy;
   logic [3:0]  count_out_s;
   logic        count_valid_s, overflow_s, stall_s, busy_s;
`ifdef STR_MONITOR_MINMAX_EN
   logic        minmax_clr;
   logic [15:0] min_count, max_count;
   logic [3:0]  min_count_s, max_count_s;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int tap_half = 0;

   str_freq_monitor #(.SYNC_STAGES(SYNC), .CNT_W(16), .GATE_W(16), .STALL_W(12)) dut (
      .CLK(clk), .RST_N(rst_n), .RING_TAP(tap), .START(start), .GATE_LEN(gate_len),
      .STALL_LIMIT(stall_limit), .COUNT_OUT(count_out), .COUNT_VALID(count_valid),
      .COUNT_READY(count_ready), .OVERFLOW(overflow), .STALL(stall), .BUSY(busy)
`ifdef STR_MONITOR_MINMAX_EN
      , .MINMAX_CLR(minmax_clr), .MIN_COUNT(min_count), .MAX_COUNT(max_count)
`endif
   );

   str_freq_monitor #(.SYNC_STAGES(SYNC), .CNT_W(4), .GATE_W(16), .STALL_W(12)) dut_sat (
      .CLK(clk), .RST_N(rst_n), .RING_TAP(tap), .START(start), .GATE_LEN(gate_len),
      .STALL_LIMIT(stall_limit), .COUNT_OUT(count_out_s), .COUNT_VALID(count_valid_s),
      .COUNT_READY(count_ready), .OVERFLOW(overflow_s), .STALL(stall_s), .BUSY(busy_s)
`ifdef STR_MONITOR_MINMAX_EN
      , .MINMAX_CLR(minmax_clr), .MIN_COUNT(min_count_s), .MAX_COUNT(max_count_s)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Free-running tap: toggles every tap_half cycles, idle when tap_half is 0
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         if (tap_half != 0) begin
            ph++;
            if (ph >= tap_half) begin
               ph  = 0;
               tap = ~tap;
            end
         end else begin
            ph = 0;
         end
      end
   end

   task automatic start_window(input int len);
      start    = 1'b1;
      gate_len = 16'(len);
      tick();
      start    = 1'b0;
   endtask

   // Runs until BUSY falls (COUNT_READY assumed high), capturing the reported values
   task automatic collect(output int cnt, output int ovf, output int cnt_s, output int ovf_s,
                          output int busy_n, output int valid_n);
      int guard;
      cnt = -1; ovf = -1; cnt_s = -1; ovf_s = -1; busy_n = 0; valid_n = 0; guard = 0;
      while (busy && guard < 2000) begin
         busy_n++;
         if (count_valid) begin
            valid_n++;
            cnt   = int'(count_out);
            ovf   = int'(overflow);
            cnt_s = int'(count_out_s);
            ovf_s = int'(overflow_s);
         end
         tick();
         guard++;
      end
      check_eq("window_done", 32'(busy), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_count"}, 32'(count_out), 0);
      check_eq({tag, "_valid"}, 32'(count_valid), 0);
      check_eq({tag, "_ovf"}, 32'(overflow), 0);
      check_eq({tag, "_stall"}, 32'(stall), 0);
      check_eq({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      int cnt, ovf, cnt_s, ovf_s, busy_n, valid_n, n, first, seen;
      rst_n = 1'b0; tap = 1'b0; start = 1'b0; gate_len = '0;
      stall_limit = 12'd20; count_ready = 1'b1;
`ifdef STR_MONITOR_MINMAX_EN
      minmax_clr = 1'b0;
`endif
      ticks(2);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tap_half = 4;
      ticks(20);

      // Basic frequency: period 8, 80-cycle window
      start_window(80);
      collect(cnt, ovf, cnt_s, ovf_s, busy_n, valid_n);
      check_eq("basic_count", 32'(cnt), 10);
      check_eq("basic_ovf", 32'(ovf), 0);
      check_eq("basic_busy_cycles", 32'(busy_n), 81);
      check_eq("basic_valid_pulses", 32'(valid_n), 1);

      // Backpressure then back-to-back window
      count_ready = 1'b0;
      start_window(80);
      n = 0;
      while (!count_valid && n < 200) begin
         tick();
         n++;
      end
      check_eq("bp_latency", 32'(n), 80);
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_hold_count", 32'(count_out), 10);
         check_eq("bp_hold_valid", 32'(count_valid), 1);
         tick();
      end
      count_ready = 1'b1;
      start = 1'b1;
      gate_len = 16'd80;
      check_eq("bp_6th_valid", 32'(count_valid), 1);
      tick();
      start = 1'b0;
      check_eq("bp_xfer_valid", 32'(count_valid), 0);
      check_eq("bp_xfer_busy", 32'(busy), 1);
      collect(cnt, ovf, cnt_s, ovf_s, busy_n, valid_n);
      check_eq("bp_second_count", 32'(cnt), 10);
      check_eq("bp_second_busy", 32'(busy_n), 81);

      // Saturation: period 4, 20 rises into a 4-bit counter, then 4 rises
      tap_half = 2;
      ticks(10);
      start_window(80);
      collect(cnt, ovf, cnt_s, ovf_s, busy_n, valid_n);
      check_eq("sat_count4", 32'(cnt_s), 15);
      check_eq("sat_ovf4", 32'(ovf_s), 1);
      check_eq("sat_count16", 32'(cnt), 20);
      check_eq("sat_ovf16", 32'(ovf), 0);
      start_window(16);
      collect(cnt, ovf, cnt_s, ovf_s, busy_n, valid_n);
      check_eq("sat_next_count4", 32'(cnt_s), 4);
      check_eq("sat_next_ovf4", 32'(ovf_s), 0);
      check_eq("sat_next_count16", 32'(cnt), 4);

      // Reset mid-MEASURE
      tap_half = 4;
      start_window(80);
      ticks(20);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_reset_outputs("midrst");
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (count_valid || busy) seen = 1;
      end
      check_eq("midrst_no_valid", 32'(seen), 0);

      // GATE_LEN=0 is ignored
      start_window(0);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (busy) seen = 1;
         tick();
      end
      check_eq("gate0_busy", 32'(seen), 0);

      // Warm-up: tap high through reset must not produce a false rise
      tap_half = 0;
      tap = 1'b1;
      ticks(3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      start = 1'b1;
      gate_len = 16'd10;
      tick();
      start = 1'b0;
      collect(cnt, ovf, cnt_s, ovf_s, busy_n, valid_n);
      check_eq("warm_count", 32'(cnt), 0);
      check_eq("warm_busy", 32'(busy_n), 11);

      // Stall detection, release, limit clamp, disable
      tap = 1'b0;
      ticks(10);
      tap = 1'b1;
      first = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (stall && first < 0) first = k;
      end
      check_eq("stall_assert_delay", 32'(first), SYNC + 22);
      check_eq("stall_held", 32'(stall), 1);
      stall_limit = 12'd10;
      #1;
      check_eq("stall_lower_limit", 32'(stall), 1);
      tick();
      stall_limit = 12'd20;
      #1;
      check_eq("stall_raise_limit", 32'(stall), 0);
      first = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (stall && first < 0) first = k;
      end
      check_eq("stall_after_clamp", 32'(first), 10);
      tap = 1'b0;
      first = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (!stall && first < 0) first = k;
      end
      check_eq("stall_release_delay", 32'(first), SYNC + 2);
      stall_limit = 12'd0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (stall) seen = 1;
      end
      check_eq("stall_disabled", 32'(seen), 0);
      stall_limit = 12'd20;

`ifdef STR_MONITOR_MINMAX_EN
      tap_half = 4;
      minmax_clr = 1'b1;
      tick();
      minmax_clr = 1'b0;
      check_eq("mm_clr_min", 32'(min_count), 32'hFFFF);
      check_eq("mm_clr_max", 32'(max_count), 0);
      ticks(10);
      start_window(80);
      collect(cnt, ovf, cnt_s, ovf_s, busy_n, valid_n);
      check_eq("mm_win1", 32'(cnt), 10);
      start_window(56);
      collect(cnt, ovf, cnt_s, ovf_s, busy_n, valid_n);
      check_eq("mm_win2", 32'(cnt), 7);
      start_window(96);
      collect(cnt, ovf, cnt_s, ovf_s, busy_n, valid_n);
      check_eq("mm_win3", 32'(cnt), 12);
      check_eq("mm_min", 32'(min_count), 7);
      check_eq("mm_max", 32'(max_count), 12);
      minmax_clr = 1'b1;
      tick();
      minmax_clr = 1'b0;
      check_eq("mm_clr2_min", 32'(min_count), 32'hFFFF);
      check_eq("mm_clr2_max", 32'(max_count), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
